// File: rtl/raifes_qspi_slave.sv
// QSPI/QPI serial-memory slave: oversampled SCK, opcode/address/data FSM,
// byte memory port, write-enable latch, config register and QPI mode bit.
// Ports: iClk/inReset clock and sync active-low reset; iSCK/inCS/iIO*_In
// from initiator; oIO*_Out/oIO*_En line drivers; onHSB always 1;
// oMem_* byte memory port (read data valid cycle after oMem_Re);
// oQpiMode/oWEL/oCfgReg status. Requires QPI_DUMMY >= 1.
module raifes_qspi_slave #(
  parameter logic [7:0]  CR_RESET  = 8'h00,
  parameter int unsigned QPI_DUMMY = 1
) (
  input  logic        iClk,
  input  logic        inReset,
  input  logic        iSCK,
  input  logic        inCS,
  input  logic        iIO0_In,
  input  logic        iIO1_In,
  input  logic        iIO2_In,
  input  logic        iIO3_In,
  output logic        oIO0_Out,
  output logic        oIO1_Out,
  output logic        oIO2_Out,
  output logic        oIO3_Out,
  output logic        oIO0_En,
  output logic        oIO1_En,
  output logic        oIO2_En,
  output logic        oIO3_En,
  output logic        onHSB,
  output logic [23:0] oMem_Addr,
  output logic [7:0]  oMem_WData,
  output logic        oMem_We,
  output logic        oMem_Re,
  input  logic [7:0]  iMem_RData,
  output logic        oQpiMode,
  output logic        oWEL,
  output logic [7:0]  oCfgReg
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_ADDR, S_DUMMY,
    S_RDATA, S_WDATA, S_CRDATA, S_IGNORE
  } state_t;

  localparam logic [4:0] QD = 5'(QPI_DUMMY - 1);

  state_t      st_q, act;
  logic        sck_q, sck_prev_q, cs_q, armed_q;
  logic [3:0]  io_q;
  logic [4:0]  cnt_q;
  logic [7:0]  sh_q, osh_q, rbuf_q;
  logic [23:0] addr_q;
  logic        is_rd_q, is_sr_q, re_d1_q, got_q;
  logic [1:0]  pend_q;
  logic        qpi_q, wel_q, we_q, re_q;
  logic [7:0]  cfg_q, wdata_q;
  logic [23:0] maddr_q;
  logic [3:0]  out_q, en_q;

  logic        rise, fall, byte_end, addr_end, dum_end;
  logic [7:0]  sh_d, rsrc, obyte;
  logic [23:0] addr_d;

  assign rise     = sck_q & ~sck_prev_q;
  assign fall     = ~sck_q & sck_prev_q;
  assign sh_d     = qpi_q ? {sh_q[3:0], io_q}
                          : {sh_q[6:0], io_q[0]};
  assign addr_d   = qpi_q ? {addr_q[19:0], io_q}
                          : {addr_q[22:0], io_q[0]};
  assign byte_end = cnt_q == (qpi_q ? 5'd1 : 5'd7);
  assign addr_end = cnt_q == (qpi_q ? 5'd5 : 5'd23);
  assign dum_end  = cnt_q == (qpi_q ? QD : 5'd7);
  // memory data arrives only one cycle; bypass it when loading a byte
  assign rsrc     = re_d1_q ? iMem_RData : rbuf_q;
  assign obyte    = (cnt_q == 5'd0) ? rsrc : osh_q;
  // a fresh select seen in IDLE is handled as the first opcode clock
  assign act      = (st_q == S_IDLE && armed_q) ? S_OPCODE : st_q;

  always_ff @(posedge iClk) begin
    if (!inReset) begin
      st_q <= S_IDLE;     sck_q <= 1'b0;   sck_prev_q <= 1'b0;
      cs_q <= 1'b0;       armed_q <= 1'b0; io_q <= 4'h0;
      cnt_q <= 5'd0;      sh_q <= 8'h00;   osh_q <= 8'h00;
      rbuf_q <= 8'h00;    addr_q <= 24'h0; is_rd_q <= 1'b0;
      is_sr_q <= 1'b0;    re_d1_q <= 1'b0; got_q <= 1'b0;
      pend_q <= 2'b00;    qpi_q <= 1'b0;   wel_q <= 1'b0;
      we_q <= 1'b0;       re_q <= 1'b0;    cfg_q <= CR_RESET;
      wdata_q <= 8'h00;   maddr_q <= 24'h0;
      out_q <= 4'h0;      en_q <= 4'h0;
    end else begin
      sck_q      <= iSCK;
      sck_prev_q <= sck_q;
      cs_q       <= inCS;
      io_q       <= {iIO3_In, iIO2_In, iIO1_In, iIO0_In};
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      re_d1_q    <= re_q;
      if (re_d1_q) rbuf_q <= iMem_RData;
      if (cs_q) begin
        st_q    <= S_IDLE;
        cnt_q   <= 5'd0;
        en_q    <= 4'h0;
        out_q   <= 4'h0;
        armed_q <= 1'b1;
        pend_q  <= 2'b00;
        got_q   <= 1'b0;
        if (pend_q[1]) qpi_q <= pend_q[0];
        if (got_q) wel_q <= 1'b0;
      end else begin
        case (act)
          S_OPCODE: if (rise) begin
            st_q  <= S_OPCODE;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 5'd1;
            if (byte_end) begin
              cnt_q   <= 5'd0;
              is_rd_q <= 1'b0;
              is_sr_q <= 1'b0;
              st_q    <= S_IGNORE;
              case (sh_d)
                8'h06: wel_q <= 1'b1;
                8'h04: wel_q <= 1'b0;
                8'h03: begin is_rd_q <= 1'b1; st_q <= S_ADDR; end
                8'h02: st_q <= S_ADDR;
                8'h87: st_q <= S_CRDATA;
                8'h38: pend_q <= 2'b11;
                8'hF5: pend_q <= 2'b10;
                8'h05: begin
                  rbuf_q  <= {6'b0, wel_q, 1'b0};
                  is_sr_q <= 1'b1;
                  st_q    <= S_RDATA;
                end
                default: ;
              endcase
            end
          end
          S_ADDR: if (rise) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 5'd1;
            if (addr_end) begin
              cnt_q <= 5'd0;
              if (is_rd_q) begin
                re_q    <= 1'b1;
                maddr_q <= addr_d;
                addr_q  <= addr_d + 24'd1;
                st_q    <= S_DUMMY;
              end else begin
                st_q <= S_WDATA;
              end
            end
          end
          S_DUMMY: if (rise) begin
            cnt_q <= cnt_q + 5'd1;
            if (dum_end) begin
              cnt_q <= 5'd0;
              st_q  <= S_RDATA;
            end
          end
          S_RDATA: if (fall) begin
            en_q  <= qpi_q ? 4'hF : 4'h2;
            out_q <= qpi_q ? obyte[7:4] : {2'b00, obyte[7], 1'b0};
            osh_q <= qpi_q ? {obyte[3:0], 4'h0} : {obyte[6:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
            if (byte_end) begin
              cnt_q <= 5'd0;
              // prefetch the next byte as soon as this one is fully out
              if (!is_sr_q) begin
                re_q    <= 1'b1;
                maddr_q <= addr_q;
                addr_q  <= addr_q + 24'd1;
              end
            end
          end
          S_WDATA: if (rise) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 5'd1;
            if (byte_end) begin
              cnt_q <= 5'd0;
              got_q <= 1'b1;
              if (wel_q) begin
                we_q    <= 1'b1;
                wdata_q <= sh_d;
                maddr_q <= addr_q;
                addr_q  <= addr_q + 24'd1;
              end
            end
          end
          S_CRDATA: if (rise) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 5'd1;
            if (byte_end) begin
              cnt_q <= 5'd0;
              got_q <= 1'b1;
              st_q  <= S_IGNORE;
              if (wel_q) cfg_q <= sh_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign {oIO3_Out, oIO2_Out, oIO1_Out, oIO0_Out} = out_q;
  assign {oIO3_En, oIO2_En, oIO1_En, oIO0_En}     = en_q;
  assign onHSB      = 1'b1;
  assign oMem_Addr  = maddr_q;
  assign oMem_WData = wdata_q;
  assign oMem_We    = we_q;
  assign oMem_Re    = re_q;
  assign oQpiMode   = qpi_q;
  assign oWEL       = wel_q;
  assign oCfgReg    = cfg_q;

endmodule

// File: doc/raifes_qspi_slave.md
RAIFES_QSPI_SLAVE -- requirements
Module: raifes_qspi_slave

Interface
REQ-001 SHALL have parameter CR_RESET, default 8'h00, reset value of configuration register.
REQ-002 SHALL have parameter QPI_DUMMY, default 1, dummy SCK clocks between address and read data in QPI mode; SPI mode uses 8.
REQ-003 SHALL have port iClk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port inReset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports iSCK, inCS  input  1 each  QSPI clock and chip select from initiator, same clock domain as iClk.
REQ-006 SHALL have ports iIO0_In..iIO3_In  input  1 each  QSPI data lines in.
REQ-007 SHALL have ports oIO0_Out..oIO3_Out, oIO0_En..oIO3_En  output  1 each  data lines out and per-line drive enable.
REQ-008 SHALL have port onHSB  output  1  hardware store busy, constant 1 (never busy).
REQ-009 SHALL have ports oMem_Addr  output  24, oMem_WData  output  8, oMem_We  output  1, oMem_Re  output  1, iMem_RData  input  8  byte memory port; read data valid the cycle after oMem_Re.
REQ-010 SHALL have ports oQpiMode  output  1, oWEL  output  1, oCfgReg  output  8  current mode, write-enable latch and configuration register.

Function
REQ-011 SHALL register iSCK/inCS/IO inputs once; rise/fall of registered SCK detected against previous sample; SCK high and low phases each at least 1 iClk.
REQ-012 SHALL sample input bits on detected SCK rise; change driven outputs on detected SCK fall; MSB first; QPI nibble IO3=bit3..IO0=bit0; SPI input on IO0, output on IO1.
REQ-013 SHALL run FSM IDLE, OPCODE, ADDR, DUMMY, RDATA, WDATA, CRDATA, IGNORE.
REQ-014 SHALL go to IDLE, release all En, clear bit counters whenever registered inCS is high, from any state.
REQ-015 IDLE -> OPCODE on inCS low; OPCODE collects 8 bits (2 clocks QPI, 8 clocks SPI).
REQ-016 Opcode decode at last opcode bit: 8'h06 WREN sets oWEL, -> IGNORE; 8'h04 WRDI clears oWEL; 8'h03 READ and 8'h02 WRITE -> ADDR; 8'h87 WRCR -> CRDATA; 8'h38 QPIEN and 8'hF5 QPIEX -> IGNORE, pending mode change; 8'h05 RDSR -> RDATA with status {6'b0,oWEL,1'b0}; any other -> IGNORE.
REQ-017 ADDR SHALL collect 24 bits; READ -> DUMMY (QPI_DUMMY clocks QPI, 8 clocks SPI), WRITE -> WDATA.
REQ-018 oMem_Re SHALL pulse one cycle at address completion and when the last bit of each byte is shifted out; oMem_Addr increments by 1 per byte, 24-bit wrap FFFFFF -> 000000.
REQ-019 RDATA SHALL drive the first data bit on the fall ending the last dummy clock (RDSR: last opcode clock); En (IO0..3 in QPI, IO1 in SPI) asserted from that fall until inCS high; RDSR repeats status byte.
REQ-020 WDATA SHALL assemble bytes; at each completed byte, if oWEL=1, pulse oMem_We one cycle with oMem_WData/oMem_Addr, then increment address; if oWEL=0, no oMem_We.
REQ-021 Partial byte at inCS rise SHALL be discarded (no oMem_We).
REQ-022 CRDATA: first full byte loads oCfgReg if oWEL=1; further bytes ignored.
REQ-023 oWEL SHALL clear at inCS rise ending a WRITE or WRCR that received at least one complete byte.
REQ-024 QPIEN sets, QPIEX clears oQpiMode at inCS rise only, and only if the full opcode was received.
REQ-025 En SHALL never assert during OPCODE/ADDR/DUMMY/WDATA/CRDATA/IGNORE.

Reset
REQ-026 While inReset=0 at a clock edge: FSM IDLE, oQpiMode=0, oWEL=0, oCfgReg=CR_RESET, all oIO*_Out/En=0, oMem_We=0, oMem_Re=0, oMem_Addr=0, oMem_WData=0, onHSB=1.
REQ-027 Reset asserted mid-transaction SHALL abort without memory write; after release, a transaction already in progress (inCS low) is ignored until inCS high.

Verification
REQ-028 SPI: WREN; WRCR 8'h87,8'h42; QPIEN -> oWEL 1 then 0, oCfgReg=8'h42, oQpiMode=1 after third inCS rise.
REQ-029 QPI WRITE 02, addr 000010, data A1 B2 C3 D4 with WEL=1 -> four oMem_We at 000010..000013 with A1..D4, oWEL=0 after inCS rise.
REQ-030 QPI READ 03, addr 000010, 1 dummy, 8 clocks, memory returns A1..D4 -> IO nibbles A,1,B,2,C,3,D,4; En high only during data phase.
REQ-031 QPI WRITE with oWEL=0 -> no oMem_We; WRITE ending after 1.5 bytes -> exactly one oMem_We.
REQ-032 READ at FFFFFF for 2 bytes -> oMem_Re addresses FFFFFF then 000000.
REQ-033 inReset=0 during RDATA -> all En drop next cycle, oQpiMode=0, oCfgReg=CR_RESET.
